// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_pkg                                                        |
// | Shared types and helpers for the instruction-fetch buffer.       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package fetch_pkg;

  // Word-address width of the instruction ROM (512 words).
  localparam int ROM_ADDR_W = 9;

  // Instruction word substituted for faulting fetches.
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  // One queued fetch: instruction word, its byte PC and the out-of-range flag.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  // True when the byte PC lies inside a ROM of 2**aw words.
  function automatic logic pc_in_rom(input logic [31:0] pc, input int aw = ROM_ADDR_W);
    return (pc >> (aw + 2)) == 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_buffer_if                                                  |
// | ROM read port, redirect input and decode-side valid/ready queue. |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface fetch_buffer_if #(
  parameter int ADDR_W = 9
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_fault;

  // Fetch stage side.
  modport master (
    output rom_en, rom_addr, inst_valid, inst, inst_pc, inst_fault,
    input  rom_data, redirect, redirect_pc, inst_ready
  );

  // ROM / decode / branch-unit side.
  modport slave (
    input  rom_en, rom_addr, inst_valid, inst, inst_pc, inst_fault,
    output rom_data, redirect, redirect_pc, inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_queue2                                                     |
// | Two-entry synchronous FIFO of fetch entries with flush.          |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fetch_queue2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  localparam int DEPTH = 2;

  fetch_entry_t r_mem [DEPTH];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_count;
  logic         w_pop;

  // A pop on an empty queue is meaningless; drop it so count cannot underflow.
  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_count = r_count;

  // Pointer and occupancy bookkeeping; flush behaves like a reset of the queue.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wr <= ~r_wr;
      if (w_pop)  r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  // Entry storage; contents need no reset because count gates the head.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush && !rst) r_mem[r_wr] <= i_data;
  end

  // Head reads as all-zero while the queue is empty.
  always_comb begin
    o_head = '0;
    if (r_count != 2'd0) o_head = r_mem[r_rd];
  end

  // The producer only pushes into a full queue when it also pops.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !w_pop && r_count == 2'd2));

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_buffer                                                     |
// | PC owner and ROM fetch issue, with fault tagging and a 2-entry   |
// | valid/ready queue toward decode; redirect flushes the queue.     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = ROM_ADDR_W,
  parameter int          DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst,
  fetch_buffer_if.master bus
);

  localparam logic [1:0] c_full = DEPTH[1:0];

  logic [31:0]  r_pc;
  logic [1:0]   w_count;
  logic         w_pop;
  logic         w_issue;
  logic         w_fault;
  fetch_entry_t w_entry;
  fetch_entry_t w_head;

  assign w_fault = !pc_in_rom(r_pc, ADDR_W);

  // Out-of-range PCs park the ROM on its top word instead of letting the
  // truncated address alias low memory; the fetched data is discarded anyway.
  assign bus.rom_addr   = w_fault ? '1 : r_pc[ADDR_W+1:2];
  assign bus.inst_valid = (w_count != 2'd0);
  assign w_pop          = bus.inst_valid && bus.inst_ready;
  assign w_issue        = !rst && !bus.redirect && ((w_count < c_full) || w_pop);
  assign bus.rom_en     = w_issue;

  // Build the entry captured at the end of this cycle's ROM read.
  always_comb begin
    w_entry       = '0;
    w_entry.inst  = w_fault ? INST_NOP : bus.rom_data;
    w_entry.pc    = r_pc;
    w_entry.fault = w_fault;
  end

  // PC: reset, redirect target (word aligned), or advance on each issued fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect) begin
      r_pc <= bus.redirect_pc & ~32'd3;
    end else if (w_issue) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Redirect flushes; a pop in the same cycle is absorbed by the flush.
  fetch_queue2 u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_issue),
    .i_pop   (w_pop && !bus.redirect),
    .i_flush (bus.redirect),
    .i_data  (w_entry),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;
  assign bus.inst_fault = w_head.fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_buffer                                                  |
// | Directed scenarios plus randomized ready/redirect traffic against |
// | a queue-based reference model of the fetch stream.               |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_fetch_buffer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;

  fetch_buffer_if #(.ADDR_W(9)) bus ();

  fetch_buffer #(.RESET_PC(RESET_PC), .ADDR_W(9), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ROM model: word k holds A000_0000 + k, sampled on the negedge when enabled.
  always @(negedge clk) begin
    if (bus.rom_en) bus.rom_data = 32'hA000_0000 + 32'(bus.rom_addr);
  end

  // Reference model: next PC to fetch and the queue of words owed to decode.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] m_pc;

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.fault = (pc >= 32'h0000_0800);
    e.inst  = e.fault ? 32'h0 : 32'hA000_0000 + (pc >> 2);
    return e;
  endfunction

  function automatic logic m_rom_en();
    return !rst && !bus.redirect &&
           (mq.size() < 2 || (mq.size() > 0 && bus.inst_ready));
  endfunction

  // Advance one clock and the reference model with it.
  task automatic tick();
    bit pop, issue;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_pc = RESET_PC;
    end else if (bus.redirect) begin
      mq.delete();
      m_pc = bus.redirect_pc & ~32'd3;
    end else begin
      pop   = (mq.size() > 0) && bus.inst_ready;
      issue = (mq.size() < 2) || pop;
      if (pop) void'(mq.pop_front());
      if (issue) begin
        mq.push_back(mk(m_pc));
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.inst_ready = 1'b0;
    tick(); tick();
    #1;
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", bus.inst_valid); end
    checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", bus.inst); end
    checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.inst_pc); end
    checks++; if (bus.inst_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0h expected 0", bus.inst_fault); end
    checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %0h expected 0", bus.rom_en); end
  endtask

  task automatic test_stream();
    rst = 1'b0; bus.inst_ready = 1'b1;
    #1;
    checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 9'h000) begin errors++; $display("FAIL stream_first_fetch: got en=%0h addr=%h expected en=1 addr=000", bus.rom_en, bus.rom_addr); end
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'hA000_0000 + 32'(k) || bus.inst_pc !== 32'(4 * k)) begin
        errors++; $display("FAIL stream_k%0d: got v=%0h inst=%h pc=%h expected v=1 inst=%h pc=%h", k, bus.inst_valid, bus.inst, bus.inst_pc, 32'hA000_0000 + 32'(k), 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_stall();
    rst = 1'b1; tick();
    rst = 1'b0; bus.inst_ready = 1'b0;
    tick(); tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (bus.rom_en !== 1'b0 || bus.rom_addr !== 9'h002) begin errors++; $display("FAIL stall_hold_c%0d: got en=%0h addr=%h expected en=0 addr=002", c, bus.rom_en, bus.rom_addr); end
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL stall_head_c%0d: got v=%0h pc=%h expected v=1 pc=0", c, bus.inst_valid, bus.inst_pc); end
      tick();
    end
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * k) || bus.inst !== 32'hA000_0000 + 32'(k)) begin
        errors++; $display("FAIL stall_release_k%0d: got v=%0h pc=%h inst=%h expected v=1 pc=%h inst=%h", k, bus.inst_valid, bus.inst_pc, bus.inst, 32'(4 * k), 32'hA000_0000 + 32'(k));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    rst = 1'b1; tick();
    rst = 1'b0; bus.inst_ready = 1'b0;
    tick(); tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
    #1;
    checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL redir_rom_en: got %0h expected 0", bus.rom_en); end
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.inst_valid !== 1'b0 || bus.rom_addr !== 9'h040) begin errors++; $display("FAIL redir_flush: got v=%0h addr=%h expected v=0 addr=040", bus.inst_valid, bus.rom_addr); end
    tick();
    #1;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst !== 32'hA000_0040) begin
      errors++; $display("FAIL redir_target: got v=%0h pc=%h inst=%h expected v=1 pc=100 inst=a0000040", bus.inst_valid, bus.inst_pc, bus.inst);
    end
  endtask

  task automatic test_fault();
    bus.inst_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_07FC;
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.rom_addr !== 9'h1FF || bus.rom_en !== 1'b1) begin errors++; $display("FAIL fault_last_word_addr: got addr=%h en=%0h expected addr=1ff en=1", bus.rom_addr, bus.rom_en); end
    tick();
    #1;
    checks++; if (bus.inst_pc !== 32'h7FC || bus.inst_fault !== 1'b0 || bus.inst !== 32'hA000_01FF) begin
      errors++; $display("FAIL fault_in_range: got pc=%h f=%0h inst=%h expected pc=7fc f=0 inst=a00001ff", bus.inst_pc, bus.inst_fault, bus.inst);
    end
    checks++; if (bus.rom_addr === 9'h000 || bus.rom_en !== 1'b1) begin errors++; $display("FAIL fault_no_alias: got addr=%h en=%0h expected addr!=000 en=1", bus.rom_addr, bus.rom_en); end
    tick();
    #1;
    checks++; if (bus.inst_pc !== 32'h800 || bus.inst_fault !== 1'b1 || bus.inst !== 32'h0) begin
      errors++; $display("FAIL fault_out_range: got pc=%h f=%0h inst=%h expected pc=800 f=1 inst=0", bus.inst_pc, bus.inst_fault, bus.inst);
    end
    tick();
    #1;
    checks++; if (bus.inst_pc !== 32'h804 || bus.inst_fault !== 1'b1) begin errors++; $display("FAIL fault_advance: got pc=%h f=%0h expected pc=804 f=1", bus.inst_pc, bus.inst_fault); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; tick();
    rst = 1'b0; bus.inst_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1; bus.inst_ready = 1'b0;
    #1;
    checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL midrst_rom_en: got %0h expected 0", bus.rom_en); end
    tick();
    rst = 1'b0; bus.inst_ready = 1'b1;
    #1;
    checks++; if (bus.inst_valid !== 1'b0 || bus.rom_addr !== RESET_PC[10:2]) begin errors++; $display("FAIL midrst_flush: got v=%0h addr=%h expected v=0 addr=%h", bus.inst_valid, bus.rom_addr, RESET_PC[10:2]); end
    tick();
    #1;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RESET_PC || bus.inst !== 32'hA000_0000 + (RESET_PC >> 2)) begin
      errors++; $display("FAIL midrst_first: got v=%0h pc=%h inst=%h expected v=1 pc=%h", bus.inst_valid, bus.inst_pc, bus.inst, RESET_PC);
    end
  endtask

  task automatic test_random();
    int next_redir;
    exp_t h;
    logic [31:0] tgt;
    next_redir = 17;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.inst_ready = ($urandom_range(0, 2) != 0);
      bus.redirect   = 1'b0;
      if (cyc == next_redir) begin
        case ($urandom_range(0, 3))
          0:       tgt = 32'h0000_07F0 + 32'($urandom_range(0, 15));
          1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          default: tgt = 32'($urandom_range(0, 32'h7FF));
        endcase
        bus.redirect    = 1'b1;
        bus.redirect_pc = tgt;
        next_redir      = cyc + 12 + $urandom_range(0, 10);
      end
      #1;
      checks++; if (bus.inst_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %0h expected %0h", cyc, bus.inst_valid, (mq.size() > 0)); end
      if (mq.size() > 0) begin
        h = mq[0];
        checks++; if (bus.inst_pc !== h.pc || bus.inst !== h.inst || bus.inst_fault !== h.fault) begin
          errors++; $display("FAIL rnd_head c%0d: got pc=%h inst=%h f=%0h expected pc=%h inst=%h f=%0h", cyc, bus.inst_pc, bus.inst, bus.inst_fault, h.pc, h.inst, h.fault);
        end
      end
      checks++; if (bus.rom_en !== m_rom_en()) begin errors++; $display("FAIL rnd_rom_en c%0d: got %0h expected %0h", cyc, bus.rom_en, m_rom_en()); end
      if (m_pc < 32'h0000_0800) begin
        checks++; if (bus.rom_addr !== 9'((m_pc >> 2) & 32'h1FF)) begin errors++; $display("FAIL rnd_rom_addr c%0d: got %h expected %h", cyc, bus.rom_addr, 9'((m_pc >> 2) & 32'h1FF)); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_fault();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
